wa_write_buffer: RTL and testbench
==================================

Name: wa_write_buffer

Overview:
- Downstream stage of the SIF block. Captures every W-side write pulse (wa_wr_s with wa_addr/wa_data_wr) into a DEPTH-entry FIFO.
- Drains entries to the consumer over a valid/ready interface, so W writes are never lost while the consumer stalls, up to DEPTH entries.
- Reports occupancy, a sticky overflow flag and a saturating drop counter for the W-side monitor and scoreboard.

Parameters:
- DEPTH, 8, FIFO entries; power of two, at least 2.
- AW, 16, address width; matches wa_addr.
- DW, 16, data width; matches wa_data_wr.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- wa_wr_s  input  1  W-side write strobe; one write per cycle it is high.
- wa_addr  input  AW  W-side write address; sampled when wa_wr_s=1.
- wa_data_wr  input  DW  W-side write data; sampled when wa_wr_s=1.
- out_valid  output  1  head entry available.
- out_ready  input  1  consumer accepts the head entry this cycle.
- out_addr  output  AW  head entry address.
- out_data  output  DW  head entry data.
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- full  output  1  count==DEPTH.
- empty  output  1  count==0.
- overflow  output  1  sticky; a write was dropped.
- overflow_clr  input  1  clears overflow and drop_cnt.
- drop_cnt  output  16  number of dropped writes; saturates at 16'hFFFF.

Behaviour:
- Single clock domain. rst is synchronous and active-high, sampled on the rising edge of clk.
- Reset values:
  - read and write pointers 0, count 0, empty 1, full 0.
  - out_valid 0, out_addr 0, out_data 0.
  - overflow 0, drop_cnt 0.
  - Storage contents are don't-care.
- Reset mid-operation discards all entries. In the cycle after rst deasserts, the block accepts a write normally.
- pop = out_valid && out_ready.
- push_req = wa_wr_s.
- push accepted = push_req && (!full || pop). A write arriving while full is accepted if the head pops in the same cycle.
- Accepted push: entry {wa_addr, wa_data_wr} written at the write pointer; write pointer increments modulo DEPTH.
- Pop: read pointer increments modulo DEPTH.
- count update:
  - +1 on push only.
  - -1 on pop only.
  - unchanged on simultaneous push and pop, including at count=0 (not possible, since out_valid=0) and count=DEPTH.
- FIFO is first-word fall-through:
  - out_valid = !empty.
  - out_addr/out_data driven from the head entry; forced to 0 when empty.
  - A write in cycle N into an empty buffer gives out_valid=1 with that entry in cycle N+1. There is no same-cycle bypass.
- out_addr/out_data stay stable while out_valid=1 and out_ready=0.
- out_ready while empty has no effect.
- Drop: push_req && full && !pop.
  - Entry is discarded and FIFO contents are unchanged.
  - Next cycle overflow=1 and drop_cnt increments, saturating at 16'hFFFF.
- overflow_clr: next cycle overflow=0 and drop_cnt=0.
  - If a drop occurs in the same cycle as overflow_clr, the drop wins: overflow=1, drop_cnt=1.
- full and empty are derived from registered count; no combinational path from inputs.
- Entries drain strictly in write order. Pointer wrap-around is invisible to the consumer.

Test Plan:
- Reset then idle: assert rst for 2 cycles with wa_wr_s=0 -> out_valid=0, empty=1, full=0, count=0, overflow=0, drop_cnt=0, out_addr=out_data=0.
- Single write latency: wa_wr_s=1, wa_addr=16'h0010, wa_data_wr=16'hBEEF in cycle N, out_ready=0 -> cycle N+1 shows out_valid=1, out_addr=16'h0010, out_data=16'hBEEF, count=1. Holding out_ready=0 for 5 cycles leaves the outputs unchanged.
- Fill, overflow, clear:
  - 8 writes with data 16'h0001..16'h0008 and out_ready=0 -> full=1, count=8.
  - 2 more writes -> overflow=1, drop_cnt=2, count=8.
  - overflow_clr pulse -> overflow=0, drop_cnt=0.
  - Drain -> data 16'h0001..16'h0008 in order, then empty=1.
- Push and pop while full: with count=8 and head 16'h0001, wa_wr_s=1 with data 16'h0009 and out_ready=1 in the same cycle -> no drop, count stays 8, new head 16'h0002. Later drain ends with 16'h0009.
- Wrap-around streaming: 20 back-to-back writes (data 16'h0100+i) with out_ready=1 every cycle -> count never exceeds 1, outputs appear in order one cycle after each write, drop_cnt=0.
- Corner cases:
  - Drop coinciding with overflow_clr -> overflow=1, drop_cnt=1.
  - rst asserted with count=5 -> next cycle count=0, out_valid=0.
  - A write in the first cycle after rst deasserts is captured normally.

Source files
------------

// File: rtl/wa_write_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : wa_write_buffer
//  Description : Write-capture FIFO on the W side of the SIF block. Every
//                cycle with wa_wr_s high offers one {wa_addr, wa_data_wr}
//                entry. Up to DEPTH entries are buffered and drained in
//                write order over a first-word-fall-through valid/ready port.
//                Writes that find the buffer full (with no same-cycle pop)
//                are dropped, which sets a sticky overflow flag and bumps a
//                saturating drop counter.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk           rising-edge clock
//    rst           synchronous active-high reset
//    wa_wr_s       write strobe, one write per high cycle
//    wa_addr       write address, sampled with wa_wr_s
//    wa_data_wr    write data, sampled with wa_wr_s
//    out_valid     head entry available (registered-state derived)
//    out_ready     consumer accepts the head entry this cycle
//    out_addr      head entry address, 0 when empty
//    out_data      head entry data, 0 when empty
//    count         occupancy 0..DEPTH
//    full          count == DEPTH
//    empty         count == 0
//    overflow      sticky: at least one write was dropped
//    overflow_clr  clears overflow and drop_cnt
//    drop_cnt      dropped-write count, saturating at 16'hFFFF
// ============================================================================
module wa_write_buffer #(
  parameter int DEPTH = 8,
  parameter int AW    = 16,
  parameter int DW    = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wa_wr_s,
  input  logic [AW-1:0]            wa_addr,
  input  logic [DW-1:0]            wa_data_wr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [AW-1:0]            out_addr,
  output logic [DW-1:0]            out_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow,
  input  logic                     overflow_clr,
  output logic [15:0]              drop_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [CW-1:0] c_full_count = CW'(DEPTH);
  localparam logic [CW-1:0] c_count_one  = CW'(1);
  localparam logic [PW-1:0] c_ptr_one    = PW'(1);
  localparam logic [15:0]   c_drop_max   = 16'hFFFF;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [AW-1:0] r_mem_addr [DEPTH];
  logic [DW-1:0] r_mem_data [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          r_overflow;
  logic [15:0]   r_drop_cnt;

  // --------------------------------------------------------------------------
  // Handshake decode. full/empty come only from the registered count, so the
  // status outputs carry no combinational path from any input.
  // --------------------------------------------------------------------------
  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == c_full_count);
  assign w_pop   = !w_empty && out_ready;
  // A write into a full buffer still fits when the head leaves this cycle.
  assign w_push  = wa_wr_s && (!w_full || w_pop);
  assign w_drop  = wa_wr_s && w_full && !w_pop;

  // --------------------------------------------------------------------------
  // Storage: contents are don't-care after reset, so no reset here.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_addr[r_wptr] <= wa_addr;
      r_mem_data[r_wptr] <= wa_data_wr;
    end
  end

  // --------------------------------------------------------------------------
  // Pointers and occupancy. DEPTH is a power of two, so the natural PW-bit
  // wrap of the pointers gives the modulo-DEPTH behaviour.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + c_ptr_one;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + c_ptr_one;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_count_one;
        2'b01:   r_count <= r_count - c_count_one;
        default: r_count <= r_count;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Overflow tracking. A drop in the same cycle as a clear wins, leaving
  // exactly one recorded drop.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (overflow_clr) begin
        r_drop_cnt <= 16'd1;
      end else if (r_drop_cnt != c_drop_max) begin
        r_drop_cnt <= r_drop_cnt + 16'd1;
      end
    end else if (overflow_clr) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: head entry falls through, forced to zero while empty.
  // --------------------------------------------------------------------------
  assign out_valid = !w_empty;
  assign out_addr  = w_empty ? '0 : r_mem_addr[r_rptr];
  assign out_data  = w_empty ? '0 : r_mem_data[r_rptr];
  assign count     = r_count;
  assign full      = w_full;
  assign empty     = w_empty;
  assign overflow  = r_overflow;
  assign drop_cnt  = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_wa_write_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wa_write_buffer
//  Description : Directed bench for wa_write_buffer. The stimulus process
//                pushes each accepted write's expected {addr,data} into a
//                queue; a separate monitor pops and compares on every
//                consumer handshake. Status outputs are checked directly
//                against hand-computed values.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_wa_write_buffer;

  localparam int DEPTH = 8;
  localparam int AW    = 16;
  localparam int DW    = 16;

  logic          clk;
  logic          rst;
  logic          wa_wr_s;
  logic [AW-1:0] wa_addr;
  logic [DW-1:0] wa_data_wr;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_addr;
  logic [DW-1:0] out_data;
  logic [3:0]    count;
  logic          full;
  logic          empty;
  logic          overflow;
  logic          overflow_clr;
  logic [15:0]   drop_cnt;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q [$];

  wa_write_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .wa_wr_s      (wa_wr_s),
    .wa_addr      (wa_addr),
    .wa_data_wr   (wa_data_wr),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_addr     (out_addr),
    .out_data     (out_data),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .overflow     (overflow),
    .overflow_clr (overflow_clr),
    .drop_cnt     (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge; drives and status checks
  // both happen here, where registered outputs have settled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_write(input logic [15:0] a, input logic [15:0] d, input bit expect_accept);
    wa_wr_s    = 1'b1;
    wa_addr    = a;
    wa_data_wr = d;
    if (expect_accept) exp_q.push_back({a, d});
  endtask

  // Monitor: every consumer handshake must deliver the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL drain_unexpected: got addr 0x%0h data 0x%0h, expected nothing", out_addr, out_data);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if ({out_addr, out_data} !== e) begin
          errors++;
          $display("FAIL drain_order: got addr 0x%0h data 0x%0h expected addr 0x%0h data 0x%0h",
                   out_addr, out_data, e[31:16], e[15:0]);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; wa_wr_s = 1'b0; wa_addr = '0; wa_data_wr = '0;
    out_ready = 1'b0; overflow_clr = 1'b0;

    // Reset then idle
    tick(); tick();
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_count", {28'd0, count}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    chk("rst_drop", {16'd0, drop_cnt}, 32'd0);
    chk("rst_outs", {out_addr, out_data}, 32'd0);
    rst = 1'b0;

    // Single write latency and hold under stall
    set_write(16'h0010, 16'hBEEF, 1'b1);
    tick();
    wa_wr_s = 1'b0;
    chk("lat_valid", {31'd0, out_valid}, 32'd1);
    chk("lat_entry", {out_addr, out_data}, 32'h0010_BEEF);
    chk("lat_count", {28'd0, count}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_entry", {out_valid, 15'd0, out_data} ^ {16'd0, out_addr}, {1'b1, 15'd0, 16'hBEEF} ^ 32'h0000_0010);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("lat_drained", {31'd0, empty}, 32'd1);

    // Fill to full
    for (int i = 0; i < DEPTH; i++) begin
      set_write(16'h0200 + 16'(i), 16'(i + 1), 1'b1);
      tick();
    end
    wa_wr_s = 1'b0;
    chk("fill_full", {31'd0, full}, 32'd1);
    chk("fill_count", {28'd0, count}, 32'd8);
    chk("fill_ovf", {31'd0, overflow}, 32'd0);

    // Two dropped writes
    set_write(16'hDEAD, 16'hDEAD, 1'b0);
    tick(); tick();
    wa_wr_s = 1'b0;
    chk("drop_ovf", {31'd0, overflow}, 32'd1);
    chk("drop_cnt2", {16'd0, drop_cnt}, 32'd2);
    chk("drop_count", {28'd0, count}, 32'd8);
    chk("drop_head", {out_addr, out_data}, 32'h0200_0001);

    // Clear
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    chk("clr_ovf", {31'd0, overflow}, 32'd0);
    chk("clr_drop", {16'd0, drop_cnt}, 32'd0);

    // Push and pop while full
    set_write(16'h0209, 16'h0009, 1'b1);
    out_ready = 1'b1;
    tick();
    wa_wr_s = 1'b0; out_ready = 1'b0;
    chk("pp_count", {28'd0, count}, 32'd8);
    chk("pp_drop", {16'd0, drop_cnt}, 32'd0);
    chk("pp_head", {out_addr, out_data}, 32'h0201_0002);

    // One drop, then a drop coinciding with clear
    set_write(16'hDEAD, 16'hBAD1, 1'b0);
    tick();
    chk("drop1_cnt", {16'd0, drop_cnt}, 32'd1);
    set_write(16'hDEAD, 16'hBAD2, 1'b0);
    overflow_clr = 1'b1;
    tick();
    wa_wr_s = 1'b0; overflow_clr = 1'b0;
    chk("dropclr_ovf", {31'd0, overflow}, 32'd1);
    chk("dropclr_cnt", {16'd0, drop_cnt}, 32'd1);

    // Drain: monitor expects 0x0002..0x0009
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) tick();
    out_ready = 1'b0;
    chk("drain_empty", {31'd0, empty}, 32'd1);
    chk("drain_outs", {out_addr, out_data}, 32'd0);
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;

    // Wrap-around streaming with the consumer always ready
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      set_write(16'h0300 + 16'(i), 16'h0100 + 16'(i), 1'b1);
      tick();
      chk("stream_entry", {out_valid, 11'd0, count, out_data}, {1'b1, 11'd0, 4'd1, 16'h0100 + 16'(i)});
    end
    wa_wr_s = 1'b0;
    tick();
    out_ready = 1'b0;
    chk("stream_count", {28'd0, count}, 32'd0);
    chk("stream_drop", {16'd0, drop_cnt}, 32'd0);

    // Reset with five entries held; they are discarded, not expected
    for (int i = 0; i < 5; i++) begin
      set_write(16'h0400 + 16'(i), 16'h0A00 + 16'(i), 1'b0);
      tick();
    end
    wa_wr_s = 1'b0;
    chk("pre_rst_count", {28'd0, count}, 32'd5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_count", {28'd0, count}, 32'd0);
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);

    // Write in the first cycle after reset deasserts
    set_write(16'h0500, 16'hCAFE, 1'b1);
    tick();
    wa_wr_s = 1'b0;
    chk("postrst_entry", {out_addr, out_data}, 32'h0500_CAFE);
    chk("postrst_count", {28'd0, count}, 32'd1);
    out_ready = 1'b1;
    tick();
    // out_ready while empty has no effect
    tick();
    out_ready = 1'b0;
    chk("idle_ready_count", {28'd0, count}, 32'd0);
    chk("idle_ready_empty", {31'd0, empty}, 32'd1);

    tick();
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
